alu_serial_seq: RTL and testbench

Bit-serial sequencer that drives a single 1-bit ALU slice across a WIDTH-bit word, one bit per clock. It sits between the datapath and the ALU slice and owns the slice's full interface: the operand bits, `sel[3:0]`, `Cin` and `less` going in, and `out`, `Cout` and `set` coming back. It returns a WIDTH-bit result plus zero and overflow flags, trading WIDTH copies of the slice for WIDTH cycles of latency. It also implements the two-pass set-less-than that the slice cannot complete alone.

---
 rtl/alu_serial_seq.sv | 130 +++++++++++++
 tb/tb_alu_serial_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial sequencer driving a single 1-bit ALU slice
// LSB-first, one bit per clock; SLT runs a forced add/sub compare pass before the result pass.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_sel,
  output logic             alu_less,
  input  logic             alu_out,
  input  logic             alu_cout,
  input  logic             alu_set,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             carry_q, less_q, zero_q, ovf_q;
  logic             last, is_slt, drive;

  assign last     = (idx == LAST_IDX);
  assign is_slt   = (op_q[1:0] == 2'b11);
  assign drive    = (state == PRE) || (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign zero     = zero_q;
  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Slice inputs depend only on registered state, never on start.
  always_comb begin
    state_next = state;
    alu_a      = 1'b0;
    alu_b      = 1'b0;
    alu_cin    = 1'b0;
    alu_sel    = 4'b0000;
    alu_less   = 1'b0;
    if (drive) begin
      alu_a   = a_q[idx];
      alu_b   = b_q[idx];
      alu_cin = (idx == '0) ? op_q[2] : carry_q;
    end
    case (state)
      IDLE: if (start) state_next = (op[1:0] == 2'b11) ? PRE : RUN;
      PRE: begin
        alu_sel = {op_q[3:2], 2'b10};
        if (last) state_next = RUN;
      end
      RUN: begin
        alu_sel  = op_q;
        alu_less = (is_slt && idx == '0) ? less_q : 1'b0;
        if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      less_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= op;
          idx     <= '0;
          carry_q <= op[2];
        end
        PRE: begin
          carry_q <= alu_cout;
          if (last) begin
            // Sign of the exact difference: MSB sum corrected by signed overflow.
            less_q  <= alu_set ^ (alu_cin ^ alu_cout);
            ovf_q   <= alu_cin ^ alu_cout;
            idx     <= '0;
            carry_q <= op_q[2];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RUN: begin
          carry_q     <= alu_cout;
          result[idx] <= alu_out;
          if (last) begin
            idx    <= '0;
            zero_q <= !alu_out && (result[WIDTH-2:0] == '0);
            if (op_q[1:0] == 2'b10) ovf_q <= alu_cin ^ alu_cout;
            else if (!is_slt)       ovf_q <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - scoreboard bench for alu_serial_seq with a 1-bit slice model
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         alu_a, alu_b, alu_cin, alu_less, alu_out, alu_cout, alu_set;
  logic [3:0]   alu_sel;
  logic [W-1:0] result;
  logic         zero, overflow, busy, done;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel), .alu_less(alu_less),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_set(alu_set),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Classic 1-bit ALU slice: optional input inversion, full adder, set = adder sum.
  logic sa, sb, ssum;
  always_comb begin
    sa       = alu_a ^ alu_sel[3];
    sb       = alu_b ^ alu_sel[2];
    ssum     = sa ^ sb ^ alu_cin;
    alu_cout = (sa & sb) | (sa & alu_cin) | (sb & alu_cin);
    alu_set  = ssum;
    case (alu_sel[1:0])
      2'b00:   alu_out = sa & sb;
      2'b01:   alu_out = sa | sb;
      2'b10:   alu_out = ssum;
      default: alu_out = alu_less;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Word-level reference: exact signed arithmetic on the (optionally inverted) operands.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [W-1:0] av, bv;
    longint ex;
    longint maxv, minv;
    logic ovf;
    av   = o[3] ? ~x : x;
    bv   = o[2] ? ~y : y;
    ex   = longint'(av) + longint'(bv) + longint'(o[2]);
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    ovf  = (ex > maxv) || (ex < minv);
    case (o[1:0])
      2'b00:   e.res = av & bv;
      2'b01:   e.res = av | bv;
      2'b10:   e.res = W'(ex);
      default: e.res = (ex < 0) ? W'(1) : W'(0);
    endcase
    e.ov       = o[1] ? ovf : 1'b0;
    e.z        = (e.res == '0);
    e.done_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_single_cycle", prev_done, 1'b0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("overflow", overflow, e.ov);
        chk("done_latency", cyc, e.done_cyc);
      end
    end
    prev_done <= done;
  end

  // Call at a negedge; waits (bounded) for IDLE, then presents start for one edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    exp_t e;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=idle");
    end else begin
      op_i  = o;
      a_i   = x;
      b_i   = y;
      start = 1'b1;
      e = model(o, x, y);
      e.done_cyc = cyc + 1 + ((o[1:0] == 2'b11) ? 2 * W : W);
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_result"}, result, '0);
    chk({nm, "_flags"}, {zero, overflow, busy, done}, 4'b0000);
    chk({nm, "_slice"}, {alu_a, alu_b, alu_cin, alu_sel, alu_less}, 8'h00);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    op_i  = '0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'b0010, 8'h7F, 8'h01);
    issue(4'b0110, 8'h05, 8'h05);
    issue(4'b0110, 8'h80, 8'h01);
    issue(4'b0000, 8'hF0, 8'h3C);
    issue(4'b0001, 8'hF0, 8'h0F);
    issue(4'b1100, 8'h00, 8'h00);
    issue(4'b1100, 8'hF0, 8'h0F);
    issue(4'b0111, 8'hFD, 8'h02);
    issue(4'b0111, 8'h02, 8'hFD);
    issue(4'b0111, 8'h80, 8'h7F);

    // Second start at edge 3 must be ignored.
    issue(4'b0010, 8'h11, 8'h22);
    @(negedge clk);
    @(negedge clk);
    op_i  = 4'b0001;
    a_i   = 8'hFF;
    b_i   = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_done", done, 1'b1);
    // Start held through DONE is only taken in the following IDLE cycle.
    op_i  = 4'b0000;
    a_i   = 8'hAA;
    b_i   = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    chk("idle_after_done", busy, 1'b0);
    issue(4'b0000, 8'hAA, 8'h0F);

    // Reset in the middle of an ADD.
    while (busy) @(negedge clk);
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    op_i  = 4'b0010;
    a_i   = 8'h33;
    b_i   = 8'h44;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0010, 8'h01, 8'h02);

    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
    end

    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
